// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic operation scheduler: opcodes,
// FSM state encoding and the default operand width.
package arith_pkg;

  localparam int WIDTH_DEF = 3;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_MUL = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : arith_pkg

// File: rtl/arith_unit.sv
// Shared combinational add/multiply datapath. The add result carries its
// carry in bit WIDTH and is zero-extended to the full 2*WIDTH result.
module arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result
);

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

  // Both results are computed in parallel; the opcode only selects.
  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b};
    w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    if (i_op == OP_ADD) begin
      o_result = {{(WIDTH-1){1'b0}}, w_sum};
    end else begin
      o_result = w_prod;
    end
  end

endmodule : arith_unit

// File: rtl/arith_op_scheduler.sv
// Two-requester round-robin scheduler in front of a shared add/multiply
// unit. One operation is in flight at a time: IDLE accepts, EXEC computes
// from registered operands, RESP holds the tagged result until consumed.
module arith_op_scheduler
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic               req0_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic               req1_op,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_id,
  output logic               rsp_op,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  state_t             r_state;
  state_t             w_next_state;

  logic               r_prio;
  logic               r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_id;
  logic [2*WIDTH-1:0] r_rsp_data;
  logic               r_rsp_id;
  logic               r_rsp_op;
  logic [CNT_W-1:0]   r_count;

  logic               w_sel;
  logic               w_any;
  logic               w_accept;
  logic               w_rsp_fire;
  logic               w_req_op;
  logic [WIDTH-1:0]   w_req_a;
  logic [WIDTH-1:0]   w_req_b;
  logic [2*WIDTH-1:0] w_result;

  // Round-robin selection: a lone requester wins outright, a tie goes to
  // the requester the priority pointer favours.
  always_comb begin
    w_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_sel = r_prio;
    end else begin
      w_sel = req1_valid;
    end
    w_req_op = w_sel ? req1_op : req0_op;
    w_req_a  = w_sel ? req1_a  : req0_a;
    w_req_b  = w_sel ? req1_b  : req0_b;
  end

  // Next-state and handshake decode; ready is only ever offered from IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    w_accept     = 1'b0;
    w_rsp_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept     = 1'b1;
          req0_ready   = ~w_sel;
          req1_ready   = w_sel;
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        w_next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_fire   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture on grant and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
      r_op   <= OP_MUL;
      r_a    <= '0;
      r_b    <= '0;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_prio <= ~w_sel;
      r_op   <= w_req_op;
      r_a    <= w_req_a;
      r_b    <= w_req_b;
      r_id   <= w_sel;
    end
  end

  arith_unit #(
    .WIDTH    (WIDTH)
  ) u_arith_unit (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_result)
  );

  // Result capture in EXEC; the registers then hold steady through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_id   <= 1'b0;
      r_rsp_op   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_data <= w_result;
      r_rsp_id   <= r_id;
      r_rsp_op   <= r_op;
    end
  end

  // Completed-response counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_rsp_fire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_op    = r_rsp_op;
  assign op_count  = r_count;

endmodule : arith_op_scheduler

// File: doc/arith_op_scheduler.md
Name: arith_op_scheduler

Overview:
Sequencing controller that shares one 3-bit add/multiply datapath between two requesters. Each requester presents an operation over a valid/ready handshake. A round-robin arbiter grants one requester at a time, and the block registers the operands and runs them through the datapath. It returns a tagged result over a valid/ready response channel. It sits between the tile input decoding and the shared arithmetic unit.

Parameters:
WIDTH, 3, operand width in bits; result width is 2*WIDTH
CNT_W, 8, width of the completed-operation counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation pending
req0_op  input  1  requester 0 opcode: 1=add, 0=multiply
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_ready  output  1  requester 0 operation accepted this cycle
req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  2*WIDTH  result; add result zero-extended from WIDTH+1 bits
rsp_id  output  1  index of the requester that owns rsp_data
rsp_op  output  1  opcode of the returned result
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-low; clock is the single clk domain. Reset values:
  - state=IDLE
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_op=0
  - busy=0, op_count=0
  - priority pointer prio=0 (requester 0 favoured)
  - req*_ready=0
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and one-hot (or zero). It is asserted only in IDLE, only for the selected requester, and only when that requester's valid is high.
  - Selection rule:
    - Only one valid: that requester is selected.
    - Both valid: requester prio is selected.
    - Neither valid: no ready is asserted.
  - On handshake: register op, a, b and id, set prio to the other index, and go to EXEC.
- EXEC:
  - Exactly one cycle. Registered operands drive the datapath, and the result is captured into rsp_data/rsp_id/rsp_op. Go to RESP.
- RESP:
  - rsp_valid=1 and outputs are held stable.
  - When rsp_ready=1: increment op_count and go to IDLE. rsp_valid drops in the next cycle.
  - Without rsp_ready, stay in RESP indefinitely.
- Latency and throughput:
  - Accept in cycle t gives rsp_valid=1 in cycle t+2.
  - Maximum throughput is one operation per 3 cycles.
  - There is no acceptance during EXEC or RESP, and no bypass of IDLE.
- Arithmetic:
  - Multiply: full unsigned product, 2*WIDTH bits.
  - Add: unsigned sum with carry in bit WIDTH; upper bits are 0.
  - Wrap-around: op_count rolls from 2^CNT_W-1 to 0 silently.
- Boundary conditions:
  - Requester valid dropping before grant: the requester is never granted, and no state changes.
  - Valid held high after grant: treated as a new request once IDLE is re-entered, and the round-robin applies.
  - Reset asserted mid-operation: in-flight operation discarded, all registers return to reset values immediately, and no response is produced.
  - rsp_ready high outside RESP: ignored.

Decomposition:
- Shared package arith_pkg:
  - OP_ADD=1'b1, OP_MUL=1'b0
  - State enum {IDLE, EXEC, RESP}
  - Default WIDTH constant
- One combinational sub-module, arith_unit: inputs op, a, b; output 2*WIDTH result. It is the shared add/multiply datapath.
- The arbiter, FSM, operand registers and counter stay in the scheduler.

Test Plan:
- Reset, then req0 add a=5 b=7 with rsp_ready=1 -> req0_ready in cycle 0; rsp_valid at cycle 2 with rsp_data=12, rsp_id=0, rsp_op=1; op_count=1.
- req1 multiply a=7 b=7 -> rsp_data=49, rsp_id=1, rsp_op=0; overflow edge case 7+7 add -> rsp_data=14.
- Both requesters valid continuously after reset, each doing multiply 3*2 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; all rsp_data=6.
- rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_data held, no new ready, busy=1; rsp_ready high -> IDLE next cycle.
- rst_n low during EXEC -> rsp_valid stays 0; after release, the first grant goes to requester 0 when both are valid.
- 256 consecutive operations -> op_count returns to 0.
